// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 frame sequencer: state encoding,
// I2C control bytes, the slave address and the window-set command stream.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_WIN  = 3'd2,
    ST_PREF = 3'd3,
    ST_DATA = 3'd4
  } state_t;

  localparam logic [7:0] CTRL_CMD     = 8'h00;
  localparam logic [7:0] CTRL_DATA    = 8'h40;
  localparam logic [6:0] SSD1306_ADDR = 7'h3C;

  // Column range 0..127 and page range 0..3, sent before every frame.
  localparam logic [7:0] WIN_CMD0 = 8'h21;
  localparam logic [7:0] WIN_CMD1 = 8'h00;
  localparam logic [7:0] WIN_CMD2 = 8'h7F;
  localparam logic [7:0] WIN_CMD3 = 8'h22;
  localparam logic [7:0] WIN_CMD4 = 8'h00;
  localparam logic [7:0] WIN_CMD5 = 8'h03;

  function automatic logic [7:0] win_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    win_byte = WIN_CMD0;
      3'd1:    win_byte = WIN_CMD1;
      3'd2:    win_byte = WIN_CMD2;
      3'd3:    win_byte = WIN_CMD3;
      3'd4:    win_byte = WIN_CMD4;
      3'd5:    win_byte = WIN_CMD5;
      default: win_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/oled_frame_sequencer_if.sv
// Byte-stream bus between the frame sequencer (master modport) and the
// I2C master that serialises it (slave modport).
interface oled_frame_sequencer_if;
  logic [6:0] addr_byte;
  logic       read_write;
  logic [7:0] control_byte;
  logic [7:0] data_byte;
  logic       continue_bit;
  logic       byte_ack;
  logic       byte_nack;

  modport master (
    output addr_byte, read_write, control_byte, data_byte, continue_bit,
    input  byte_ack, byte_nack
  );

  modport slave (
    input  addr_byte, read_write, control_byte, data_byte, continue_bit,
    output byte_ack, byte_nack
  );
endinterface

// File: rtl/oled_init_rom.sv
// SSD1306 power-up command sequence for a 128x32 panel, 26 bytes.
module oled_init_rom (
  input  logic [4:0] addr,
  output logic [7:0] data
);
  always_comb begin
    data = 8'h00;
    case (addr)
      5'd0:  data = 8'hAE;
      5'd1:  data = 8'hD5;
      5'd2:  data = 8'h80;
      5'd3:  data = 8'hA8;
      5'd4:  data = 8'h1F;
      5'd5:  data = 8'hD3;
      5'd6:  data = 8'h00;
      5'd7:  data = 8'h40;
      5'd8:  data = 8'h8D;
      5'd9:  data = 8'h14;
      5'd10: data = 8'h20;
      5'd11: data = 8'h00;
      5'd12: data = 8'hA1;
      5'd13: data = 8'hC8;
      5'd14: data = 8'hDA;
      5'd15: data = 8'h02;
      5'd16: data = 8'h81;
      5'd17: data = 8'h8F;
      5'd18: data = 8'hD9;
      5'd19: data = 8'hF1;
      5'd20: data = 8'hDB;
      5'd21: data = 8'h40;
      5'd22: data = 8'hA4;
      5'd23: data = 8'hA6;
      5'd24: data = 8'h2E;
      5'd25: data = 8'hAF;
      default: data = 8'h00;
    endcase
  end
endmodule

// File: rtl/oled_frame_sequencer.sv
// Feeds the I2C master one init stream, then loops window-set + framebuffer
// streams, advancing one byte per ACK and aborting to IDLE on NACK.
module oled_frame_sequencer
  import oled_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = SSD1306_ADDR,
  parameter int         INIT_LEN   = 26,
  parameter int         WIN_LEN    = 6,
  parameter int         FB_BYTES   = 512,
  parameter bit         CONTINUOUS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  oled_frame_sequencer_if.master bus,
  output logic [8:0]            fb_rd_addr,
  input  logic [7:0]            fb_rd_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error
);

  localparam logic [9:0] INIT_LAST = 10'(INIT_LEN - 1);
  localparam logic [9:0] WIN_LAST  = 10'(WIN_LEN - 1);
  localparam logic [9:0] FB_LAST   = 10'(FB_BYTES - 1);

  state_t     state;
  logic [9:0] byte_idx;
  logic       init_done;
  logic [7:0] rom_data;

  oled_init_rom u_rom (
    .addr (byte_idx[4:0]),
    .data (rom_data)
  );

  assign bus.addr_byte  = SLAVE_ADDR;
  assign bus.read_write = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      byte_idx         <= '0;
      init_done        <= 1'b0;
      fb_rd_addr       <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      error            <= 1'b0;
      bus.control_byte <= CTRL_CMD;
      bus.data_byte    <= 8'h00;
      bus.continue_bit <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // NACK takes priority over a coincident ACK in every active state
      if (state != ST_IDLE && bus.byte_nack) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        error <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            state    <= init_done ? ST_WIN : ST_INIT;
            byte_idx <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
          end
          ST_INIT: if (bus.byte_ack) begin
            if (byte_idx == INIT_LAST) begin
              init_done <= 1'b1;
              state     <= ST_WIN;
              byte_idx  <= '0;
            end else begin
              byte_idx <= byte_idx + 10'd1;
            end
          end
          ST_WIN: if (bus.byte_ack) begin
            if (byte_idx == WIN_LAST) begin
              state      <= ST_PREF;
              byte_idx   <= '0;
              fb_rd_addr <= '0;
            end else begin
              byte_idx <= byte_idx + 10'd1;
            end
          end
          ST_PREF: state <= ST_DATA;
          ST_DATA: if (bus.byte_ack) begin
            fb_rd_addr <= fb_rd_addr + 9'd1;
            if (byte_idx == FB_LAST) begin
              frame_done <= 1'b1;
              byte_idx   <= '0;
              state      <= CONTINUOUS ? ST_WIN : ST_IDLE;
              busy       <= CONTINUOUS;
            end else begin
              byte_idx <= byte_idx + 10'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // Offered byte follows state/index one cycle later; IDLE and PREF hold it
      case (state)
        ST_INIT: begin
          bus.control_byte <= CTRL_CMD;
          bus.data_byte    <= rom_data;
          bus.continue_bit <= (byte_idx != INIT_LAST);
        end
        ST_WIN: begin
          bus.control_byte <= CTRL_CMD;
          bus.data_byte    <= win_byte(byte_idx[2:0]);
          bus.continue_bit <= (byte_idx != WIN_LAST);
        end
        ST_DATA: begin
          bus.control_byte <= CTRL_DATA;
          bus.data_byte    <= fb_rd_data;
          bus.continue_bit <= (byte_idx != FB_LAST);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Scoreboard bench: the driver queues each expected byte, a monitor pops and
// compares when the modelled master latches the offered byte.
module tb_oled_frame_sequencer;
  import oled_pkg::*;

  typedef struct packed {
    logic [7:0] ctrl;
    logic [7:0] data;
    logic       cont;
    logic       chk_addr;
    logic [8:0] addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] fb_rd_addr;
  logic [7:0] fb_rd_data = 8'h00;
  logic       busy, frame_done, error;
  logic       latch = 1'b0;

  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t cur;

  logic [7:0] rom_exp [26] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00,
                               8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8,
                               8'hDA, 8'h02, 8'h81, 8'h8F, 8'hD9, 8'hF1, 8'hDB,
                               8'h40, 8'hA4, 8'hA6, 8'h2E, 8'hAF};
  logic [7:0] win_exp [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

  oled_frame_sequencer_if bus ();

  oled_frame_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
    .busy       (busy),
    .frame_done (frame_done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM model, 1-cycle read latency, RAM[i] = i[7:0] ^ 0x5A
  always @(posedge clk) fb_rd_data <= fb_rd_addr[7:0] ^ 8'h5A;

  always @(negedge clk) begin
    if (latch) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL byte: latched data=%02h with no expectation queued", bus.data_byte);
      end else begin
        cur = sb.pop_front();
        if (bus.control_byte !== cur.ctrl || bus.data_byte !== cur.data ||
            bus.continue_bit !== cur.cont || bus.addr_byte !== 7'h3C ||
            bus.read_write !== 1'b0 || (cur.chk_addr && fb_rd_addr !== cur.addr)) begin
          n_fail++;
          $display("FAIL byte: got ctrl=%02h data=%02h cont=%0b addr=%0d dev=%02h rw=%0b, expected ctrl=%02h data=%02h cont=%0b addr=%0d",
                   bus.control_byte, bus.data_byte, bus.continue_bit, fb_rd_addr,
                   bus.addr_byte, bus.read_write, cur.ctrl, cur.data, cur.cont, cur.addr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t e_cmd(input logic [7:0] d, input logic c);
    exp_t e;
    e.ctrl = 8'h00; e.data = d; e.cont = c; e.chk_addr = 1'b0; e.addr = 9'd0;
    return e;
  endfunction

  function automatic exp_t e_dat(input int i);
    exp_t e;
    logic [8:0] a;
    a = 9'(i);
    e.ctrl = 8'h40; e.data = a[7:0] ^ 8'h5A; e.cont = (i != 511);
    e.chk_addr = 1'b1; e.addr = a;
    return e;
  endfunction

  // Queue expectation, let the monitor latch, then answer with ack/nack.
  task automatic send(input exp_t e, input logic ack, input logic nack);
    repeat (4) @(posedge clk);
    #1; sb.push_back(e); latch = 1'b1;
    @(posedge clk);
    #1; latch = 1'b0; bus.byte_ack = ack; bus.byte_nack = nack;
    @(posedge clk);
    #1; bus.byte_ack = 1'b0; bus.byte_nack = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1; start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_error"}, 32'(error), 32'(0));
    check({tag, "_frame_done"}, 32'(frame_done), 32'(0));
    check({tag, "_data"}, 32'(bus.data_byte), 32'(8'h00));
    check({tag, "_ctrl"}, 32'(bus.control_byte), 32'(8'h00));
    check({tag, "_cont"}, 32'(bus.continue_bit), 32'(0));
    check({tag, "_fb_addr"}, 32'(fb_rd_addr), 32'(0));
  endtask

  task automatic send_win();
    for (int w = 0; w < 6; w++) send(e_cmd(win_exp[w], w != 5), 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_ack = 1'b0;
    bus.byte_nack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    check("por_dev_addr", 32'(bus.addr_byte), 32'(7'h3C));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ACK and NACK together at INIT index 5
    pulse_start();
    check("start_busy", 32'(busy), 32'(1));
    for (int i = 0; i < 5; i++) send(e_cmd(rom_exp[i], 1'b1), 1'b1, 1'b0);
    send(e_cmd(rom_exp[5], 1'b1), 1'b1, 1'b1);
    check("acknack_error", 32'(error), 32'(1));
    check("acknack_busy", 32'(busy), 32'(0));
    repeat (4) @(posedge clk);
    #1;
    check("acknack_hold_data", 32'(bus.data_byte), 32'(8'hD3));

    // Full init stream (init never completed, so it restarts at 0xAE)
    pulse_start();
    check("restart_error_clr", 32'(error), 32'(0));
    for (int i = 0; i < 26; i++) send(e_cmd(rom_exp[i], i != 25), 1'b1, 1'b0);

    // First frame
    send_win();
    for (int d = 0; d < 512; d++) begin
      send(e_dat(d), 1'b1, 1'b0);
      if (d == 510) check("fd_early", 32'(frame_done), 32'(0));
    end
    check("frame_done_pulse", 32'(frame_done), 32'(1));
    @(posedge clk);
    #1;
    check("frame_done_single", 32'(frame_done), 32'(0));
    check("continuous_busy", 32'(busy), 32'(1));

    // Second frame loops to WIN without INIT, NACK at data index 100
    send_win();
    for (int d = 0; d < 100; d++) send(e_dat(d), 1'b1, 1'b0);
    send(e_dat(100), 1'b0, 1'b1);
    check("nack_error", 32'(error), 32'(1));
    check("nack_busy", 32'(busy), 32'(0));

    // Restart resumes at WIN; reset lands mid-frame at index 300
    pulse_start();
    check("resume_error_clr", 32'(error), 32'(0));
    send_win();
    for (int d = 0; d < 300; d++) send(e_dat(d), 1'b1, 1'b0);
    send(e_dat(300), 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // init_done was cleared, so INIT begins again
    pulse_start();
    send(e_cmd(8'hAE, 1'b1), 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
